// File: rtl/cnn_win_addr_gen.sv
// Serpentine KxK window sweep: emits only the SRAM read addresses the window
// register array is missing, with slot index, bit-plane and padding flag.
module cnn_win_addr_gen #(
  parameter int KSIZE   = 3,
  parameter int COORD_W = 8,
  parameter int NPLANE  = 8,
  parameter int ADDR_W  = 11,
  parameter int SLOT_W  = $clog2(KSIZE*KSIZE),
  parameter int PLANE_W = (NPLANE > 1) ? $clog2(NPLANE) : 1
) (
  input  logic               SYS_CLK,
  input  logic               SYS_RST,
  input  logic               start,
  input  logic [COORD_W-1:0] cfg_pic_w,
  input  logic [COORD_W-1:0] cfg_pic_h,
  input  logic               cfg_pad,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [SLOT_W-1:0]  slot_o,
  output logic [PLANE_W-1:0] plane_o,
  output logic               pad_o,
  output logic               win_step,
  output logic               busy,
  output logic               done
);

  localparam int P   = (KSIZE - 1) / 2;
  localparam int SW  = COORD_W + 2;
  localparam int IW  = $clog2(2 * KSIZE);
  localparam int PSH = $clog2(NPLANE);
  localparam int LW  = 2 * COORD_W + ADDR_W;

  localparam logic [IW-1:0]        K_I     = IW'(KSIZE);
  localparam logic [IW-1:0]        KM1_I   = IW'(KSIZE - 1);
  localparam logic [SLOT_W-1:0]    K_S     = SLOT_W'(KSIZE);
  localparam logic [PLANE_W-1:0]   PL_LAST = PLANE_W'(NPLANE - 1);
  localparam logic signed [SW:0]   P_S     = (SW+1)'(P);
  localparam logic signed [SW:0]   KM1_S   = (SW+1)'(KSIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FULL, S_RIGHT, S_LEFT, S_DOWN, S_DONE
  } state_t;

  state_t                r_state;
  logic [COORD_W-1:0]    r_w, r_h;
  logic [SW-1:0]         r_owm1, r_ohm1;
  logic signed [SW-1:0]  r_wx, r_wy;
  logic [SW-1:0]         r_wcol, r_wrow;
  logic [IW-1:0]         r_r, r_c, r_rb, r_cb;
  logic [PLANE_W-1:0]    r_plane;

  state_t                w_nx_state;
  logic [COORD_W-1:0]    w_nx_w, w_nx_h;
  logic [SW-1:0]         w_nx_owm1, w_nx_ohm1;
  logic signed [SW-1:0]  w_nx_wx, w_nx_wy;
  logic [SW-1:0]         w_nx_wcol, w_nx_wrow;
  logic [IW-1:0]         w_nx_r, w_nx_c, w_nx_rb, w_nx_cb;
  logic [PLANE_W-1:0]    w_nx_plane;
  logic                  w_nx_valid, w_nx_win, w_nx_busy, w_nx_done;

  logic                  w_fire, w_last, w_empty;
  logic                  w_go_right, w_go_left, w_go_down;
  logic signed [SW:0]    w_wext, w_hext, w_padamt, w_ow, w_oh, w_org;
  logic signed [SW-1:0]  w_x, w_y;
  logic                  w_oob;
  logic [LW-1:0]         w_lin;
  logic [ADDR_W-1:0]     w_addr;
  logic [IW-1:0]         w_sr, w_sc, w_rm, w_cm;
  logic [SLOT_W-1:0]     w_slot;

  always_comb begin
    w_fire   = addr_valid & addr_ready;
    w_wext   = $signed({{(SW+1-COORD_W){1'b0}}, cfg_pic_w});
    w_hext   = $signed({{(SW+1-COORD_W){1'b0}}, cfg_pic_h});
    w_padamt = cfg_pad ? P_S : '0;
    w_ow     = w_wext + w_padamt + w_padamt - KM1_S;
    w_oh     = w_hext + w_padamt + w_padamt - KM1_S;
    w_empty  = w_ow[SW] | (w_ow == '0) | w_oh[SW] | (w_oh == '0);
    w_org    = -w_padamt;

    w_go_right = !r_wrow[0] && (r_wcol != r_owm1);
    w_go_left  = r_wrow[0] && (r_wcol != '0);
    w_go_down  = !w_go_right && !w_go_left && (r_wrow != r_ohm1);

    w_last = 1'b0;
    case (r_state)
      S_FULL:  w_last = (r_r == KM1_I) && (r_c == KM1_I);
      S_DOWN:  w_last = (r_c == KM1_I);
      default: w_last = (r_r == KM1_I);
    endcase

    w_nx_state = r_state;
    w_nx_w     = r_w;
    w_nx_h     = r_h;
    w_nx_owm1  = r_owm1;
    w_nx_ohm1  = r_ohm1;
    w_nx_wx    = r_wx;
    w_nx_wy    = r_wy;
    w_nx_wcol  = r_wcol;
    w_nx_wrow  = r_wrow;
    w_nx_r     = r_r;
    w_nx_c     = r_c;
    w_nx_rb    = r_rb;
    w_nx_cb    = r_cb;
    w_nx_plane = r_plane;
    w_nx_valid = addr_valid;
    w_nx_win   = 1'b0;
    w_nx_busy  = busy;
    w_nx_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nx_w     = cfg_pic_w;
          w_nx_h     = cfg_pic_h;
          w_nx_owm1  = w_ow[SW-1:0] - 1'b1;
          w_nx_ohm1  = w_oh[SW-1:0] - 1'b1;
          w_nx_wx    = w_org[SW-1:0];
          w_nx_wy    = w_org[SW-1:0];
          w_nx_wcol  = '0;
          w_nx_wrow  = '0;
          w_nx_r     = '0;
          w_nx_c     = '0;
          w_nx_rb    = '0;
          w_nx_cb    = '0;
          w_nx_plane = '0;
          w_nx_busy  = 1'b1;
          w_nx_state = w_empty ? S_DONE : S_FULL;
          w_nx_valid = !w_empty;
        end
      end
      S_FULL, S_RIGHT, S_LEFT, S_DOWN: begin
        if (w_fire) begin
          if (!w_last) begin
            if (r_state == S_FULL) begin
              if (r_c == KM1_I) begin
                w_nx_c = '0;
                w_nx_r = r_r + 1'b1;
              end else begin
                w_nx_c = r_c + 1'b1;
              end
            end else if (r_state == S_DOWN) begin
              w_nx_c = r_c + 1'b1;
            end else begin
              w_nx_r = r_r + 1'b1;
            end
          end else if (r_plane != PL_LAST) begin
            w_nx_plane = r_plane + 1'b1;
            if (r_state != S_DOWN) w_nx_r = '0;
            if (r_state != S_RIGHT && r_state != S_LEFT) w_nx_c = '0;
          end else begin
            w_nx_win   = 1'b1;
            w_nx_plane = '0;
            w_nx_r     = '0;
            w_nx_c     = '0;
            unique case (1'b1)
              w_go_right: begin
                w_nx_state = S_RIGHT;
                w_nx_wx    = r_wx + 1'b1;
                w_nx_wcol  = r_wcol + 1'b1;
                w_nx_cb    = (r_cb == KM1_I) ? '0 : r_cb + 1'b1;
                w_nx_c     = KM1_I;
              end
              w_go_left: begin
                w_nx_state = S_LEFT;
                w_nx_wx    = r_wx - 1'b1;
                w_nx_wcol  = r_wcol - 1'b1;
                w_nx_cb    = (r_cb == '0) ? KM1_I : r_cb - 1'b1;
              end
              w_go_down: begin
                w_nx_state = S_DOWN;
                w_nx_wy    = r_wy + 1'b1;
                w_nx_wrow  = r_wrow + 1'b1;
                w_nx_rb    = (r_rb == KM1_I) ? '0 : r_rb + 1'b1;
                w_nx_r     = KM1_I;
              end
              default: begin
                w_nx_state = S_DONE;
                w_nx_valid = 1'b0;
              end
            endcase
          end
        end
      end
      S_DONE: begin
        w_nx_state = S_IDLE;
        w_nx_busy  = 1'b0;
        w_nx_done  = 1'b1;
      end
      default: w_nx_state = S_IDLE;
    endcase

    // Element of the next presented address, decoded ahead of the register.
    w_x   = w_nx_wx + $signed({{(SW-IW){1'b0}}, w_nx_c});
    w_y   = w_nx_wy + $signed({{(SW-IW){1'b0}}, w_nx_r});
    w_oob = w_x[SW-1] | w_y[SW-1]
          | (w_x >= $signed({2'b00, w_nx_w}))
          | (w_y >= $signed({2'b00, w_nx_h}));
    w_lin  = LW'(w_y[COORD_W-1:0]) * LW'(w_nx_w)
           + LW'(w_x[COORD_W-1:0]);
    w_addr = ADDR_W'(w_lin << PSH) | ADDR_W'(w_nx_plane);
    w_sr   = w_nx_r + w_nx_rb;
    w_sc   = w_nx_c + w_nx_cb;
    w_rm   = (w_sr >= K_I) ? w_sr - K_I : w_sr;
    w_cm   = (w_sc >= K_I) ? w_sc - K_I : w_sc;
    w_slot = SLOT_W'(w_rm) * K_S + SLOT_W'(w_cm);
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_h        <= '0;
      r_owm1     <= '0;
      r_ohm1     <= '0;
      r_wx       <= '0;
      r_wy       <= '0;
      r_wcol     <= '0;
      r_wrow     <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_rb       <= '0;
      r_cb       <= '0;
      r_plane    <= '0;
      addr_valid <= 1'b0;
      addr_o     <= '0;
      slot_o     <= '0;
      plane_o    <= '0;
      pad_o      <= 1'b0;
      win_step   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_nx_state;
      r_w        <= w_nx_w;
      r_h        <= w_nx_h;
      r_owm1     <= w_nx_owm1;
      r_ohm1     <= w_nx_ohm1;
      r_wx       <= w_nx_wx;
      r_wy       <= w_nx_wy;
      r_wcol     <= w_nx_wcol;
      r_wrow     <= w_nx_wrow;
      r_r        <= w_nx_r;
      r_c        <= w_nx_c;
      r_rb       <= w_nx_rb;
      r_cb       <= w_nx_cb;
      r_plane    <= w_nx_plane;
      addr_valid <= w_nx_valid;
      addr_o     <= (w_nx_valid && !w_oob) ? w_addr : '0;
      slot_o     <= w_nx_valid ? w_slot : '0;
      plane_o    <= w_nx_valid ? w_nx_plane : '0;
      pad_o      <= w_nx_valid & w_oob;
      win_step   <= w_nx_win;
      busy       <= w_nx_busy;
      done       <= w_nx_done;
    end
  end

endmodule

// File: tb/tb_cnn_win_addr_gen.sv
// Directed bench for cnn_win_addr_gen: one instance with 1 bit-plane,
// one with 8 bit-planes, sharing clock, reset, config and ready.
module tb_cnn_win_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start8 = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  cfg_w = 8'd4, cfg_h = 8'd4;
  logic        cfg_pad = 1'b0;

  logic        v0, pd0, ws0, b0, d0;
  logic [10:0] a0;
  logic [3:0]  s0;
  logic [0:0]  p0;
  logic        v8, pd8, ws8, b8, d8;
  logic [10:0] a8;
  logic [3:0]  s8;
  logic [2:0]  p8;

  logic        sel8 = 1'b0;
  logic        m_valid, m_pad, m_win, m_busy, m_done;
  logic [10:0] m_addr;
  logic [3:0]  m_slot;
  logic [2:0]  m_plane;

  always #5 clk = ~clk;

  cnn_win_addr_gen #(.KSIZE(3), .COORD_W(8), .NPLANE(1), .ADDR_W(11)) u0 (
    .SYS_CLK(clk), .SYS_RST(rst), .start(start0),
    .cfg_pic_w(cfg_w), .cfg_pic_h(cfg_h), .cfg_pad(cfg_pad),
    .addr_valid(v0), .addr_ready(ready), .addr_o(a0), .slot_o(s0),
    .plane_o(p0), .pad_o(pd0), .win_step(ws0), .busy(b0), .done(d0));

  cnn_win_addr_gen #(.KSIZE(3), .COORD_W(8), .NPLANE(8), .ADDR_W(11)) u8 (
    .SYS_CLK(clk), .SYS_RST(rst), .start(start8),
    .cfg_pic_w(cfg_w), .cfg_pic_h(cfg_h), .cfg_pad(cfg_pad),
    .addr_valid(v8), .addr_ready(ready), .addr_o(a8), .slot_o(s8),
    .plane_o(p8), .pad_o(pd8), .win_step(ws8), .busy(b8), .done(d8));

  assign m_valid = sel8 ? v8 : v0;
  assign m_addr  = sel8 ? a8 : a0;
  assign m_slot  = sel8 ? s8 : s0;
  assign m_plane = sel8 ? p8 : {2'b00, p0};
  assign m_pad   = sel8 ? pd8 : pd0;
  assign m_win   = sel8 ? ws8 : ws0;
  assign m_busy  = sel8 ? b8 : b0;
  assign m_done  = sel8 ? d8 : d0;

  int err = 0;
  int chk = 0;

  int exp_a [18] = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                     3, 7, 11, 13, 14, 15, 4, 8, 12};
  int exp_s [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8,
                     0, 3, 6, 1, 2, 0, 3, 6, 0};
  int pix   [9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  int cap_addr [200];
  int cap_slot [200];
  int cap_pad  [200];
  int cap_plane[200];
  int hold_addr[10];
  int hold_slot[10];
  int hold_vld [10];
  int n_acc, n_win, n_done, busy_cyc, win_first, first_vld, n_hold;
  bit tmo;

  // Drives one frame on the selected instance and records what was accepted.
  task automatic run_frame(input int stall_at, input int stall_len,
                           input int restart_at);
    n_acc = 0; n_win = 0; n_done = 0; busy_cyc = 0;
    win_first = -1; first_vld = -1; n_hold = 0; tmo = 1'b0;
    ready = 1'b1;
    if (sel8) start8 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start8 = 1'b0;
    for (int cyc = 0; ; cyc++) begin
      if (cyc >= 3000) begin tmo = 1'b1; break; end
      if (m_done) begin n_done++; break; end
      if (m_busy) busy_cyc++;
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_win) begin
        n_win++;
        if (win_first < 0) win_first = n_acc;
      end
      start0 = 1'b0; start8 = 1'b0;
      if (cyc == restart_at) begin
        if (sel8) start8 = 1'b1; else start0 = 1'b1;
        cfg_w = 8'd9; cfg_h = 8'd9; cfg_pad = 1'b1;
      end
      if (stall_at >= 0 && n_acc == stall_at && n_hold < stall_len) begin
        ready = 1'b0;
        hold_addr[n_hold] = int'(m_addr);
        hold_slot[n_hold] = int'(m_slot);
        hold_vld[n_hold]  = int'(m_valid);
        n_hold++;
      end else begin
        ready = 1'b1;
      end
      if (m_valid && ready) begin
        if (n_acc < 200) begin
          cap_addr[n_acc]  = int'(m_addr);
          cap_slot[n_acc]  = int'(m_slot);
          cap_pad[n_acc]   = int'(m_pad);
          cap_plane[n_acc] = int'(m_plane);
        end
        n_acc++;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0; start8 = 1'b0; ready = 1'b1;
    if (tmo) $display("FAIL frame_timeout: no done within 3000 cycles");
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if ({v0, a0, s0, p0, pd0, ws0, b0, d0} !== '0) begin
      err++;
      $display("FAIL reset_u0: got %h expected 0",
               {v0, a0, s0, p0, pd0, ws0, b0, d0});
    end
    chk++;
    if ({v8, a8, s8, p8, pd8, ws8, b8, d8} !== '0) begin
      err++;
      $display("FAIL reset_u8: got %h expected 0",
               {v8, a8, s8, p8, pd8, ws8, b8, d8});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk++;
    if ({v0, b0, d0, ws0} !== 4'b0000) begin
      err++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {v0, b0, d0, ws0});
    end
  endtask

  task automatic check_basic_seq(input string tag);
    chk++;
    if (tmo !== 1'b0 || n_acc !== 18) begin
      err++;
      $display("FAIL %s_count: got %0d expected 18", tag, n_acc);
    end
    for (int i = 0; i < 18; i++) begin
      chk++;
      if (cap_addr[i] !== exp_a[i] || cap_slot[i] !== exp_s[i]
          || cap_pad[i] !== 0) begin
        err++;
        $display("FAIL %s_elem[%0d]: got a=%0d s=%0d p=%0d expected a=%0d s=%0d p=0",
                 tag, i, cap_addr[i], cap_slot[i], cap_pad[i],
                 exp_a[i], exp_s[i]);
      end
    end
    chk++;
    if (n_done !== 1) begin
      err++;
      $display("FAIL %s_done: got %0d expected 1", tag, n_done);
    end
  endtask

  task automatic test_basic();
    sel8 = 1'b0; cfg_w = 8'd4; cfg_h = 8'd4; cfg_pad = 1'b0;
    run_frame(-1, 0, -1);
    check_basic_seq("basic");
    chk++;
    if (n_win !== 4) begin
      err++;
      $display("FAIL basic_win_step: got %0d expected 4", n_win);
    end
    chk++;
    if (first_vld !== 0) begin
      err++;
      $display("FAIL basic_first_valid: got cycle %0d expected 0", first_vld);
    end
    chk++;
    if (busy_cyc !== 19) begin
      err++;
      $display("FAIL basic_busy_cycles: got %0d expected 19", busy_cyc);
    end
  endtask

  task automatic test_pad();
    sel8 = 1'b0; cfg_w = 8'd2; cfg_h = 8'd2; cfg_pad = 1'b1;
    run_frame(-1, 0, -1);
    chk++;
    if (tmo !== 1'b0 || n_acc !== 18) begin
      err++;
      $display("FAIL pad_count: got %0d expected 18", n_acc);
    end
    for (int i = 0; i < 3; i++) begin
      chk++;
      if (cap_pad[i] !== 1 || cap_addr[i] !== 0) begin
        err++;
        $display("FAIL pad_top[%0d]: got p=%0d a=%0d expected p=1 a=0",
                 i, cap_pad[i], cap_addr[i]);
      end
    end
    chk++;
    if (cap_pad[4] !== 0 || cap_addr[4] !== 0 || cap_slot[4] !== 4) begin
      err++;
      $display("FAIL pad_center: got p=%0d a=%0d s=%0d expected p=0 a=0 s=4",
               cap_pad[4], cap_addr[4], cap_slot[4]);
    end
    chk++;
    if (cap_pad[8] !== 0 || cap_addr[8] !== 3 || cap_slot[8] !== 8) begin
      err++;
      $display("FAIL pad_corner: got p=%0d a=%0d s=%0d expected p=0 a=3 s=8",
               cap_pad[8], cap_addr[8], cap_slot[8]);
    end
    chk++;
    if (cap_pad[9] !== 1 || cap_addr[9] !== 0) begin
      err++;
      $display("FAIL pad_right_col: got p=%0d a=%0d expected p=1 a=0",
               cap_pad[9], cap_addr[9]);
    end
  endtask

  task automatic test_planes();
    sel8 = 1'b1; cfg_w = 8'd4; cfg_h = 8'd4; cfg_pad = 1'b0;
    run_frame(-1, 0, -1);
    chk++;
    if (tmo !== 1'b0 || n_acc !== 144) begin
      err++;
      $display("FAIL planes_count: got %0d expected 144", n_acc);
    end
    for (int i = 0; i < 72; i++) begin
      chk++;
      if (cap_addr[i] !== pix[i % 9] * 8 + i / 9
          || cap_plane[i] !== i / 9) begin
        err++;
        $display("FAIL planes_elem[%0d]: got a=%0d b=%0d expected a=%0d b=%0d",
                 i, cap_addr[i], cap_plane[i], pix[i % 9] * 8 + i / 9, i / 9);
      end
    end
    chk++;
    if (win_first !== 72) begin
      err++;
      $display("FAIL planes_win_step: got after %0d expected after 72",
               win_first);
    end
    sel8 = 1'b0;
  endtask

  task automatic test_backpressure();
    sel8 = 1'b0; cfg_w = 8'd4; cfg_h = 8'd4; cfg_pad = 1'b0;
    run_frame(1, 5, 3);
    chk++;
    if (n_hold !== 5) begin
      err++;
      $display("FAIL bp_stall_len: got %0d expected 5", n_hold);
    end
    for (int i = 0; i < 5; i++) begin
      chk++;
      if (hold_addr[i] !== 1 || hold_slot[i] !== 1 || hold_vld[i] !== 1) begin
        err++;
        $display("FAIL bp_hold[%0d]: got a=%0d s=%0d v=%0d expected a=1 s=1 v=1",
                 i, hold_addr[i], hold_slot[i], hold_vld[i]);
      end
    end
    check_basic_seq("bp");
    cfg_w = 8'd4; cfg_h = 8'd4; cfg_pad = 1'b0;
  endtask

  task automatic test_empty();
    sel8 = 1'b0; cfg_w = 8'd2; cfg_h = 8'd4; cfg_pad = 1'b0;
    run_frame(-1, 0, -1);
    chk++;
    if (tmo !== 1'b0 || busy_cyc !== 1 || n_done !== 1) begin
      err++;
      $display("FAIL empty_busy_done: got busy=%0d done=%0d expected 1 1",
               busy_cyc, n_done);
    end
    chk++;
    if (first_vld !== -1 || n_acc !== 0) begin
      err++;
      $display("FAIL empty_valid: got first=%0d acc=%0d expected -1 0",
               first_vld, n_acc);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    sel8 = 1'b0; cfg_w = 8'd4; cfg_h = 8'd4; cfg_pad = 1'b0;
    ready = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 10; c++) begin
      if (v0) cnt++;
      @(posedge clk); #1;
    end
    chk++;
    if (v0 !== 1'b1 || a0 !== 11'd7) begin
      err++;
      $display("FAIL mid_position: got v=%0d a=%0d expected v=1 a=7", v0, a0);
    end
    #2 rst = 1'b1;
    #1;
    chk++;
    if ({v0, a0, s0, p0, pd0, ws0, b0, d0} !== '0) begin
      err++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {v0, a0, s0, p0, pd0, ws0, b0, d0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk++;
    if (d0 !== 1'b0 || b0 !== 1'b0) begin
      err++;
      $display("FAIL mid_no_done: got d=%0d b=%0d expected 0 0", d0, b0);
    end
    run_frame(-1, 0, -1);
    check_basic_seq("replay");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_planes();
    test_backpressure();
    test_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
